global_output_drain_ctrl: RTL and testbench
===========================================

GLOBAL_OUTPUT_DRAIN_CTRL -- requirements
Module: global_output_drain_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default `BIT_WIDTH*`LINE_SIZE: width of one poly RAM line.
REQ-002 Parameter ADDR_WIDTH, default `ADDR_WIDTH: line address width; one poly = 2**ADDR_WIDTH lines.
REQ-003 Parameter CNT_WIDTH, default 16: width of poly_cnt.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rstn  in  1  asynchronous, active-low reset.
REQ-006 auto_drain  in  1  1 = begin a poly read automatically whenever the output FIFO is non-empty.
REQ-007 start  in  1  one-cycle request to drain one poly; used when auto_drain=0.
REQ-008 fifo_empty  in  1  empty flag of the output poly FIFO read port.
REQ-009 fifo_rd_finish  out  1  rd_finish to the FIFO read port; low = read in progress.
REQ-010 fifo_addrA / fifo_addrB  out  ADDR_WIDTH each  FIFO read addresses.
REQ-011 fifo_dA / fifo_dB  in  DATA_WIDTH each  FIFO read data, valid one cycle after the address.
REQ-012 m_data  out  2*DATA_WIDTH  output beat {line 2k+1, line 2k}; dB in the upper half.
REQ-013 m_valid / m_ready / m_last  out / in / out  1 each  stream handshake; m_last marks the final beat of a poly.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 poly_done  out  1  one-cycle pulse when a poly is fully delivered.
REQ-016 poly_cnt  out  CNT_WIDTH  number of polys delivered since reset; wraps modulo 2**CNT_WIDTH.

Function
REQ-017 States: IDLE, READ, DRAIN, FINISH.
- IDLE: fifo_rd_finish=1.
- IDLE -> READ when !fifo_empty && (auto_drain || start); start while empty or busy is dropped, not queued.
- READ: fifo_rd_finish=0; issues BEATS = 2**(ADDR_WIDTH-1) reads.
- READ -> DRAIN on the cycle the last read is issued.
- DRAIN -> FINISH when buffer occupancy=0 and nothing is in flight.
- FINISH: fifo_rd_finish=1 for exactly one cycle, which advances the FIFO read pointer; poly_done=1; poly_cnt increments; next state is IDLE.
REQ-018 Read k (k = 0..BEATS-1) drives fifo_addrA=2k and fifo_addrB=2k+1; addresses are 0 when no read is issued.
REQ-019 RAM read latency is exactly 1 cycle. Data for read k is captured into a 2-entry output FIFO buffer on the cycle after issue.
REQ-020 Issue condition: occupancy + inflight - pop < 2, where pop = m_valid && m_ready.
- Guarantees no buffer overflow.
- Sustains 1 beat/cycle when m_ready is held high.
REQ-021 m_valid = (occupancy > 0). m_data and m_last stay stable while m_valid && !m_ready. Beats leave in address order with no loss or duplication.
REQ-022 m_last=1 only on beat BEATS-1 of each poly.
REQ-023 Beat counter and issue counter are ADDR_WIDTH-1 bits and clear on entry to READ.
REQ-024 Minimum latency with m_ready=1: first m_valid 2 cycles after leaving IDLE.
REQ-025 Back-to-back polys: after FINISH, IDLE re-evaluates the updated fifo_empty, giving at least 1 idle cycle between polys.
REQ-026 auto_drain or start changing during READ/DRAIN has no effect on the poly in progress.

Reset
REQ-027 rstn low immediately (asynchronously) forces the following, including mid-operation; a partially read poly is not completed, and its FIFO slot is re-read after reset:
- state = IDLE;
- fifo_rd_finish = 1;
- fifo_addrA = fifo_addrB = 0;
- m_valid = m_last = 0, m_data = 0;
- busy = poly_done = 0;
- poly_cnt = 0;
- buffer, inflight and all counters cleared.
REQ-028 Reset release is synchronised internally; the first state change is possible on the second rising edge after rstn rises.

Verification (ADDR_WIDTH=4, BEATS=8)
REQ-029 Reset: assert rstn=0 asynchronously mid-cycle -> all outputs take their REQ-027 values before the next clock edge.
REQ-030 Single poly: auto_drain=1, fifo_empty falls, m_ready=1 ->
- fifo_rd_finish falls the next cycle;
- address pairs run (0,1) through (14,15);
- 8 consecutive beats, m_last on beat 8;
- one FINISH cycle, then poly_cnt=1.
REQ-031 Backpressure: m_ready toggles 1,0,1,0 -> exactly 8 beats, in order, m_data stable during stalls, and never more than 2 reads outstanding beyond consumption.
REQ-032 Empty and start: auto_drain=0, start=1 with fifo_empty=1 -> stays IDLE, fifo_rd_finish=1, no beats; a later start with fifo_empty=0 drains one poly.
REQ-033 Back-to-back: FIFO holds 2 polys, auto_drain=1 -> 16 beats with 2 m_last, 2 poly_done pulses, poly_cnt=2.
REQ-034 Reset mid-READ after 3 beats -> outputs reset immediately; after release, a full 8-beat poly restarts from address 0.

Source files
------------

// File: rtl/global_output_drain_ctrl.sv
// -----------------------------------------------------------------------------
// global_output_drain_ctrl
//
// Drains one polynomial at a time from the read port of the output poly FIFO
// and streams it out as 2-line beats over a valid/ready interface.
//
// A poly occupies 2**ADDR_WIDTH RAM lines. Each read fetches the line pair
// (2k, 2k+1) through the two RAM ports, so a poly is BEATS = 2**(ADDR_WIDTH-1)
// beats. Read data arrives one cycle after the address and lands in a 2-entry
// output buffer whose head register drives m_data directly.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   auto_drain, start    drain trigger: automatic when FIFO non-empty, or a
//                        one-cycle start request
//   fifo_empty           output poly FIFO empty flag
//   fifo_rd_finish       low while a poly is being read; its one-cycle high
//                        pulse after a read advances the FIFO read pointer
//   fifo_addrA/B         line read addresses (0 when no read is issued)
//   fifo_dA/dB           line read data, valid one cycle after the address
//   m_data/m_valid/
//   m_ready/m_last       output beat stream, {line 2k+1, line 2k}
//   busy                 not idle
//   poly_done            one-cycle pulse when a poly has been fully delivered
//   poly_cnt             polys delivered since reset (wrapping)
// -----------------------------------------------------------------------------
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif
`ifndef LINE_SIZE
`define LINE_SIZE 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

module global_output_drain_ctrl #(
  parameter int DATA_WIDTH = `BIT_WIDTH * `LINE_SIZE,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    auto_drain,
  input  logic                    start,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_finish,
  output logic [ADDR_WIDTH-1:0]   fifo_addrA,
  output logic [ADDR_WIDTH-1:0]   fifo_addrB,
  input  logic [DATA_WIDTH-1:0]   fifo_dA,
  input  logic [DATA_WIDTH-1:0]   fifo_dB,
  output logic [2*DATA_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy,
  output logic                    poly_done,
  output logic [CNT_WIDTH-1:0]    poly_cnt
);

  localparam int BW = ADDR_WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    run_q, run_d;
  logic [BW-1:0]           iss_cnt_q, iss_cnt_d;
  logic [BW-1:0]           beat_cnt_q, beat_cnt_d;
  logic                    infl_q, infl_d;
  logic                    sec_vld_q, sec_vld_d;
  logic [2*DATA_WIDTH-1:0] sec_data_q, sec_data_d;
  logic                    m_valid_q, m_valid_d;
  logic [2*DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                    m_last_q, m_last_d;
  logic                    rd_finish_q, rd_finish_d;
  logic                    busy_q, busy_d;
  logic                    poly_done_q, poly_done_d;
  logic [CNT_WIDTH-1:0]    poly_cnt_q, poly_cnt_d;

  logic [1:0]              occ;
  logic                    pop;
  logic                    issue;

  // Buffer occupancy is head + second entry. A read issued now lands in the
  // buffer at the end of the next cycle, so it is safe whenever everything
  // already committed (buffered + in flight) minus this cycle's pop leaves a
  // free slot. With m_ready held high this settles at one issue per cycle.
  assign occ   = {1'b0, m_valid_q} + {1'b0, sec_vld_q};
  assign pop   = m_valid_q & m_ready;
  assign issue = (state_q == S_READ) &&
                 (({1'b0, occ} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop}));

  // Addresses are decoded from the issue counter in the issuing cycle so the
  // 1-cycle RAM latency lines up with a single in-flight slot.
  assign fifo_addrA = issue ? {iss_cnt_q, 1'b0} : '0;
  assign fifo_addrB = issue ? {iss_cnt_q, 1'b1} : '0;

  assign fifo_rd_finish = rd_finish_q;
  assign m_data         = m_data_q;
  assign m_valid        = m_valid_q;
  assign m_last         = m_last_q;
  assign busy           = busy_q;
  assign poly_done      = poly_done_q;
  assign poly_cnt       = poly_cnt_q;

  always_comb begin
    state_d     = state_q;
    run_d       = 1'b1;
    iss_cnt_d   = iss_cnt_q;
    beat_cnt_d  = beat_cnt_q + {{(BW-1){1'b0}}, pop};
    infl_d      = issue;
    sec_vld_d   = sec_vld_q;
    sec_data_d  = sec_data_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;

    unique case (state_q)
      S_IDLE: begin
        // run_q gates the first transition until reset release has been
        // seen on a clock edge.
        if (run_q && !fifo_empty && (auto_drain || start)) begin
          state_d    = S_READ;
          iss_cnt_d  = '0;
          beat_cnt_d = '0;
        end
      end
      S_READ: begin
        if (issue) begin
          iss_cnt_d = iss_cnt_q + 1'b1;
          if (&iss_cnt_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (occ == 2'd0 && !infl_q) state_d = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pop shifts the second entry into the head; arriving data fills the
    // head if it is free, otherwise the second entry.
    if (pop) begin
      m_valid_d = sec_vld_q;
      m_data_d  = sec_data_q;
      sec_vld_d = 1'b0;
    end
    if (infl_q) begin
      if (!m_valid_d) begin
        m_valid_d = 1'b1;
        m_data_d  = {fifo_dB, fifo_dA};
      end else begin
        sec_vld_d  = 1'b1;
        sec_data_d = {fifo_dB, fifo_dA};
      end
    end

    // The head beat's index within the poly equals the beats already popped.
    m_last_d    = m_valid_d && (&beat_cnt_d);

    busy_d      = (state_d != S_IDLE);
    rd_finish_d = (state_d == S_IDLE) || (state_d == S_FINISH);
    poly_done_d = (state_d == S_FINISH);
    poly_cnt_d  = poly_cnt_q + {{(CNT_WIDTH-1){1'b0}}, (state_d == S_FINISH)};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      iss_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      infl_q      <= 1'b0;
      sec_vld_q   <= 1'b0;
      sec_data_q  <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      rd_finish_q <= 1'b1;
      busy_q      <= 1'b0;
      poly_done_q <= 1'b0;
      poly_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      iss_cnt_q   <= iss_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      infl_q      <= infl_d;
      sec_vld_q   <= sec_vld_d;
      sec_data_q  <= sec_data_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      rd_finish_q <= rd_finish_d;
      busy_q      <= busy_d;
      poly_done_q <= poly_done_d;
      poly_cnt_q  <= poly_cnt_d;
    end
  end

endmodule

// File: tb/tb_global_output_drain_ctrl.sv
// Bench for global_output_drain_ctrl with ADDR_WIDTH=4 (8 beats per poly).
// The environment models the poly FIFO as a ring of poly seeds; each RAM line
// value is a function of (seed, line address). Expected beats are derived from
// the poly at the FIFO head and the beat index within that poly.
module tb_global_output_drain_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 16;
  localparam int BEATS = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          auto_drain;
  logic          start;
  logic          fifo_empty;
  logic          fifo_rd_finish;
  logic [AW-1:0] fifo_addrA, fifo_addrB;
  logic [DW-1:0] fifo_dA, fifo_dB;
  logic [2*DW-1:0] m_data;
  logic          m_valid, m_ready, m_last;
  logic          busy, poly_done;
  logic [CW-1:0] poly_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] slot_seed [0:7];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_base = 0;
  int rdy_mode = 0;

  // monitor state
  int bk = 0, ik = 0, pend = 0;
  int beats_total = 0, lasts_total = 0, dones_total = 0;
  logic rdf_prev = 1'b1;
  logic stall_prev = 1'b0;
  logic [2*DW-1:0] prev_data;
  logic prev_last;
  logic [AW-1:0] a_lat, b_lat;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  global_output_drain_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .auto_drain(auto_drain), .start(start),
    .fifo_empty(fifo_empty), .fifo_rd_finish(fifo_rd_finish),
    .fifo_addrA(fifo_addrA), .fifo_addrB(fifo_addrB),
    .fifo_dA(fifo_dA), .fifo_dB(fifo_dB),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .poly_done(poly_done), .poly_cnt(poly_cnt)
  );

  function automatic logic [31:0] line_val(input logic [31:0] seed, input int a);
    return seed ^ (32'(a) * 32'h0100_0193) ^ {24'h0, 8'(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Synchronous-read RAM: address seen in a cycle, data presented next cycle.
  always @(negedge clk) begin
    a_lat = fifo_addrA;
    b_lat = fifo_addrB;
  end
  always @(posedge clk) begin
    fifo_dA <= line_val(slot_seed[rd_ptr % 8], int'(a_lat));
    fifo_dB <= line_val(slot_seed[rd_ptr % 8], int'(b_lat));
  end

  // m_ready: 0 = held high, 1 = toggling, 2 = random
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       m_ready = ~m_ready;
        2:       m_ready = 1'($urandom % 2);
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Stream / address monitor and FIFO pointer model.
  always @(negedge clk) begin
    logic [2*DW-1:0] exp_beat;
    if (!rstn) begin
      bk = 0; ik = 0; pend = 0;
      rdf_prev = 1'b1;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_data", m_data, prev_data);
        chk("stall_last", 64'(m_last), 64'(prev_last));
      end
      if (fifo_addrB != '0) begin
        chk("addr_pair", {56'h0, fifo_addrA, fifo_addrB},
            {56'h0, 4'(2 * ik), 4'(2 * ik + 1)});
        ik++;
        pend++;
      end
      if (m_valid && m_ready) begin
        exp_beat = {line_val(slot_seed[rd_ptr % 8], 2 * bk + 1),
                    line_val(slot_seed[rd_ptr % 8], 2 * bk)};
        chk("beat_data", m_data, exp_beat);
        chk("beat_last", 64'(m_last), 64'(bk == BEATS - 1));
        if (m_last) lasts_total++;
        bk++;
        pend--;
        beats_total++;
      end
      if (fifo_addrB != '0) chk("outstanding", 64'(pend <= 2), 64'd1);
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (poly_done) begin
        chk("done_beats", 64'(bk), 64'(BEATS));
        chk("done_reads", 64'(ik), 64'(BEATS));
        bk = 0; ik = 0; pend = 0;
        dones_total++;
      end
      if (fifo_rd_finish && !rdf_prev) rd_ptr++;
      rdf_prev = fifo_rd_finish;
    end
  end

  task automatic push_poly();
    slot_seed[wr_ptr % 8] = $urandom;
    wr_ptr++;
  endtask

  task automatic check_reset(input string p);
    chk({p, "_rdf"},   64'(fifo_rd_finish), 64'd1);
    chk({p, "_addrA"}, 64'(fifo_addrA), 64'd0);
    chk({p, "_addrB"}, 64'(fifo_addrB), 64'd0);
    chk({p, "_valid"}, 64'(m_valid), 64'd0);
    chk({p, "_last"},  64'(m_last), 64'd0);
    chk({p, "_data"},  m_data, 64'd0);
    chk({p, "_busy"},  64'(busy), 64'd0);
    chk({p, "_done"},  64'(poly_done), 64'd0);
    chk({p, "_cnt"},   64'(poly_cnt), 64'd0);
  endtask

  // Wait (bounded) until idle with an empty FIFO, then check the poly count.
  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy && fifo_empty) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk({tag, "_timeout"}, 64'd0, 64'd1);
    chk({tag, "_cnt"}, 64'(poly_cnt), 64'(CW'(wr_ptr - rd_base)));
  endtask

  task automatic wait_not_busy(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int b0, l0, d0, n;
    bit hit;
    for (int i = 0; i < 8; i++) slot_seed[i] = '0;
    rstn = 1'b1; auto_drain = 1'b0; start = 1'b0;

    // Power-on reset asserted mid-cycle
    #2 rstn = 1'b0;
    #1 check_reset("por");
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    rd_base = rd_ptr;
    repeat (3) @(negedge clk);

    // Single poly, m_ready high: latency and consecutive beats
    rdy_mode = 0;
    auto_drain = 1'b1;
    push_poly();
    @(negedge clk);
    chk("single_rdf_fall", 64'(fifo_rd_finish), 64'd0);
    chk("single_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("single_lat_c2", 64'(m_valid), 64'd0);
    for (int i = 0; i < BEATS; i++) begin
      @(negedge clk);
      chk("single_consec", 64'(m_valid), 64'd1);
      chk("single_last", 64'(m_last), 64'(i == BEATS - 1));
    end
    wait_idle("single");
    chk("single_cnt1", 64'(poly_cnt), 64'd1);

    // Backpressure: m_ready toggling
    rdy_mode = 1;
    b0 = beats_total;
    push_poly();
    wait_idle("bp");
    chk("bp_beats", 64'(beats_total - b0), 64'd8);
    rdy_mode = 0;

    // start with an empty FIFO is dropped
    auto_drain = 1'b0;
    @(negedge clk);
    pulse_start();
    repeat (3) begin
      @(negedge clk);
      chk("empty_busy", 64'(busy), 64'd0);
      chk("empty_rdf", 64'(fifo_rd_finish), 64'd1);
      chk("empty_valid", 64'(m_valid), 64'd0);
    end
    push_poly();
    repeat (3) begin
      @(negedge clk);
      chk("nostart_busy", 64'(busy), 64'd0);
    end
    pulse_start();
    wait_idle("start");

    // Back-to-back polys
    auto_drain = 1'b1;
    l0 = lasts_total; d0 = dones_total; b0 = beats_total;
    push_poly();
    push_poly();
    wait_idle("b2b");
    chk("b2b_beats", 64'(beats_total - b0), 64'd16);
    chk("b2b_lasts", 64'(lasts_total - l0), 64'd2);
    chk("b2b_dones", 64'(dones_total - d0), 64'd2);

    // Reset in the middle of a read after 3 beats
    push_poly();
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (bk >= 3) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) chk("midrst_timeout", 64'd0, 64'd1);
    #1 rstn = 1'b0;
    #1 check_reset("midrst");
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    rd_base = rd_ptr;
    wait_idle("midrst");
    chk("midrst_cnt1", 64'(poly_cnt), 64'd1);

    // Randomized traffic
    rdy_mode = 2;
    for (int it = 0; it < 8; it++) begin
      n = 1 + int'($urandom % 2);
      auto_drain = 1'($urandom % 2);
      for (int j = 0; j < n; j++) push_poly();
      if (!auto_drain) begin
        for (int j = 0; j < n; j++) begin
          @(negedge clk);
          pulse_start();
          wait_not_busy("rand_start");
        end
      end
      wait_idle("rand");
      repeat (int'($urandom % 4)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
